// File: rtl/spi_mstr16.sv
// spi_mstr16: 16-bit SPI master, mode 3 (SCLK idles high, sample on rise,
// drive on fall). One full-duplex 16-bit exchange per wrt pulse.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   wrt      one-clk start pulse, accepted only while idle
//   cmd      16-bit word shifted out MSB first
//   done     set at end of transfer, held until next accepted wrt
//   rd_data  16-bit word shifted in from MISO
//   SS_n     active-low slave select
//   SCLK     serial clock, period 2**DIV_W clk
//   MOSI     serial data out (MSB of shift register)
//   MISO     serial data in
module spi_mstr16 #(
    parameter int DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    // Load value gives a quarter-period of SCLK-high front porch.
    localparam logic [DIV_W-1:0] DIV_LOAD =
        DIV_W'(2**DIV_W - 2**(DIV_W-2));
    localparam logic [DIV_W-1:0] DIV_SMPL = DIV_W'(2**(DIV_W-1) - 1);
    localparam logic [DIV_W-1:0] DIV_SHFT = '1;
    localparam logic [DIV_W-1:0] DIV_BP   = DIV_W'(2**(DIV_W-2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        BACK_PORCH
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [15:0]      r_shft;
    logic [3:0]       r_bit_cnt;
    logic             r_miso_smpl;
    logic             r_first;
    logic             r_ss_n;
    logic             r_done;
    logic             w_sclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_shft      <= '0;
            r_bit_cnt   <= '0;
            r_miso_smpl <= 1'b0;
            r_first     <= 1'b0;
            r_ss_n      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (wrt) begin
                        r_shft    <= cmd;
                        r_div     <= DIV_LOAD;
                        r_bit_cnt <= '0;
                        r_first   <= 1'b1;
                        r_done    <= 1'b0;
                        r_ss_n    <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_div <= r_div + 1'b1;
                    if (r_div == DIV_SMPL) begin
                        r_miso_smpl <= MISO;
                    end
                    if (r_div == DIV_SHFT) begin
                        // MOSI already shows bit 15 on the first fall,
                        // so that fall must not shift.
                        if (r_first) begin
                            r_first <= 1'b0;
                        end else begin
                            r_shft    <= {r_shft[14:0], r_miso_smpl};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd15) begin
                                r_state <= BACK_PORCH;
                            end
                        end
                    end
                end
                BACK_PORCH: begin
                    r_div <= r_div + 1'b1;
                    if (r_div == DIV_BP) begin
                        r_ss_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // SCLK only toggles while shifting; held high otherwise so the
    // final divider wrap produces no 17th falling edge.
    assign w_sclk  = (r_state == SHIFT) ? r_div[DIV_W-1] : 1'b1;

    assign SCLK    = w_sclk;
    assign MOSI    = r_shft[15];
    assign rd_data = r_shft;
    assign SS_n    = r_ss_n;
    assign done    = r_done;

endmodule

// File: tb/tb_spi_mstr16.sv
// tb_spi_mstr16: self-checking bench for spi_mstr16 with a cycle-level
// transaction model, a MISO responder and hand-computed expectations.
module tb_spi_mstr16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        w_miso;

    logic        loop = 1'b1;
    logic [15:0] resp_w = 16'h0000;
    logic        resp_bit = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign w_miso = loop ? MOSI : resp_bit;

    spi_mstr16 dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (w_miso)
    );

    // Edge counters, MOSI capture on rises, responder on falls.
    int          rises = 0;
    int          falls = 0;
    int          fall_base = 0;
    logic [15:0] mosi_cap = 16'h0000;

    always @(posedge SCLK) begin
        if (!SS_n) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[14:0], MOSI};
        end
    end

    always @(negedge SCLK) begin
        if (!SS_n) begin
            falls    <= falls + 1;
            resp_bit <= resp_w[4'(15 - (falls - fall_base))];
        end
    end

    // Transaction model: n = clocks since the accepting edge.
    logic        m_act = 1'b0;
    logic        m_done = 1'b0;
    logic        m_rdk = 1'b0;
    logic [15:0] m_rd = 16'h0000;
    int          m_n = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_rd   <= 16'h0000;
            m_rdk  <= 1'b1;
            m_n    <= 0;
        end else if (m_act) begin
            if (m_n == 528) begin
                m_act  <= 1'b0;
                m_done <= 1'b1;
                m_rdk  <= 1'b1;
            end else begin
                m_n <= m_n + 1;
            end
        end else if (wrt) begin
            m_act  <= 1'b1;
            m_n    <= 1;
            m_done <= 1'b0;
            m_rdk  <= 1'b0;
            m_rd   <= loop ? cmd : resp_w;
        end
    end

    // 8 clk high porch, then 16 periods of 16 low / 16 high, then high.
    function automatic logic sclk_exp(int n);
        if (n <= 8 || n >= 521) return 1'b1;
        return ((n - 9) % 32) >= 16;
    endfunction

    task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        chk("SS_n", 16'(SS_n), 16'(!m_act));
        chk("SCLK", 16'(SCLK), 16'(m_act ? sclk_exp(m_n) : 1'b1));
        chk("done", 16'(done), 16'(m_done));
        if (m_rdk) chk("rd_data", rd_data, m_rd);
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) cmp_cycle();
    endtask

    // Runs one transfer; optional ignored wrt pulses at n=p1/p2.
    task automatic xfer(input logic [15:0] c, input logic lp,
                        input logic [15:0] rw, input int p1,
                        input int p2, output int lowc, output int cnt,
                        output int nr, output int nf);
        int r0;
        int f0;
        cmd       = c;
        loop      = lp;
        resp_w    = rw;
        fall_base = falls;
        r0        = rises;
        f0        = falls;
        wrt       = 1'b1;
        step();
        wrt  = 1'b0;
        lowc = 0;
        cnt  = 0;
        while (!done && cnt < 2000) begin
            if (!SS_n) lowc++;
            wrt = (cnt + 1 == p1) || (cnt + 1 == p2);
            if (wrt) cmd = ~c;
            cnt++;
            step();
        end
        wrt = 1'b0;
        if (cnt >= 2000) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen in %0d clk", cnt);
        end
        nr = rises - r0;
        nf = falls - f0;
    endtask

    task automatic chk_xfer(string nm, logic [15:0] exp_rd,
                            logic [15:0] exp_mosi, int lowc, int cnt,
                            int nr, int nf);
        chk({nm, "_rd"}, rd_data, exp_rd);
        chk({nm, "_mosi"}, mosi_cap, exp_mosi);
        chk({nm, "_low"}, 16'(lowc), 16'd528);
        chk({nm, "_lat"}, 16'(cnt), 16'd528);
        chk({nm, "_rise"}, 16'(nr), 16'd16);
        chk({nm, "_fall"}, 16'(nf), 16'd16);
    endtask

    int lowc, cnt, nr, nf;

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_ss", 16'(SS_n), 16'd1);
        chk("rst_sclk", 16'(SCLK), 16'd1);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_rd", rd_data, 16'h0000);
        chk("rst_mosi", 16'(MOSI), 16'd0);
        rst = 1'b0;
        step();

        // Loopback
        xfer(16'hA5C3, 1'b1, 16'h0, 0, 0, lowc, cnt, nr, nf);
        chk_xfer("loop", 16'hA5C3, 16'hA5C3, lowc, cnt, nr, nf);
        repeat (3) step();

        // Responder word
        xfer(16'h8F00, 1'b0, 16'h5A0F, 0, 0, lowc, cnt, nr, nf);
        chk_xfer("resp", 16'h5A0F, 16'h8F00, lowc, cnt, nr, nf);
        repeat (3) step();

        // wrt ignored while busy, including the done-rise cycle
        xfer(16'h3C96, 1'b1, 16'h0, 100, 528, lowc, cnt, nr, nf);
        chk_xfer("busy", 16'h3C96, 16'h3C96, lowc, cnt, nr, nf);
        repeat (4) step();
        chk("busy_ss", 16'(SS_n), 16'd1);
        chk("busy_done", 16'(done), 16'd1);

        // Reset mid-transfer
        cmd  = 16'h7E81;
        loop = 1'b1;
        wrt  = 1'b1;
        step();
        wrt = 1'b0;
        repeat (299) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ss", 16'(SS_n), 16'd1);
        chk("abort_sclk", 16'(SCLK), 16'd1);
        chk("abort_done", 16'(done), 16'd0);
        repeat (5) step();
        chk("abort_idle", 16'(SS_n), 16'd1);
        xfer(16'h0FF0, 1'b1, 16'h0, 0, 0, lowc, cnt, nr, nf);
        chk_xfer("after", 16'h0FF0, 16'h0FF0, lowc, cnt, nr, nf);

        // Back-to-back
        xfer(16'h1234, 1'b1, 16'h0, 0, 0, lowc, cnt, nr, nf);
        chk_xfer("b2b1", 16'h1234, 16'h1234, lowc, cnt, nr, nf);
        chk("b2b_gap", 16'(SS_n), 16'd1);
        xfer(16'hFEDC, 1'b1, 16'h0, 0, 0, lowc, cnt, nr, nf);
        chk_xfer("b2b2", 16'hFEDC, 16'hFEDC, lowc, cnt, nr, nf);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
